// File: rtl/ql_dsp_cfg_pkg.sv
// ql_dsp_cfg_pkg: shared types and constants for the QL_DSP mode-word loader.
package ql_dsp_cfg_pkg;
  typedef enum logic [2:0] {HUNT, LOAD, CRC, COMMIT, RDBK} cfg_state_e;
  localparam int QL_DSP_MODE_W = 85;
  localparam logic [7:0] QL_DSP_CFG_SYNC = 8'hA5;
  localparam logic [7:0] QL_DSP_CFG_CRC_POLY = 8'h07;
  localparam int QL_DSP_COEF0_LO = 0;
  localparam int QL_DSP_COEF0_HI = 19;
  localparam int QL_DSP_COEF1_LO = 20;
  localparam int QL_DSP_COEF1_HI = 39;
  localparam int QL_DSP_COEF2_LO = 40;
  localparam int QL_DSP_COEF2_HI = 59;
  localparam int QL_DSP_COEF3_LO = 60;
  localparam int QL_DSP_COEF3_HI = 79;
  localparam int QL_DSP_OSEL_LO = 80;
  localparam int QL_DSP_OSEL_HI = 82;
  localparam int QL_DSP_REG_IN = 83;
  localparam int QL_DSP_F_MODE = 84;
endpackage

// File: rtl/ql_dsp_cfg_crc8.sv
// ql_dsp_cfg_crc8: bit-serial CRC-8 (poly 0x07, init 0) with clear and enable.
module ql_dsp_cfg_crc8
  import ql_dsp_cfg_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       clear,
  input  logic       en,
  input  logic       bit_i,
  output logic [7:0] crc_o
);
  logic [7:0] crc_q, crc_d;
  logic fb;
  always_comb begin
    fb = crc_q[7] ^ bit_i;
    crc_d = clear ? 8'h00 : en ? ({crc_q[6:0], 1'b0} ^ (fb ? QL_DSP_CFG_CRC_POLY : 8'h00)) : crc_q;
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) crc_q <= 8'h00;
    else crc_q <= crc_d;
  assign crc_o = crc_q;
endmodule

// File: rtl/ql_dsp_cfg_loader.sv
// ql_dsp_cfg_loader: serial sync/payload/CRC frame loader for the QL_DSP mode word.
// Serial readback of the committed word is built only with QL_DSP_CFG_READBACK_EN.
module ql_dsp_cfg_loader
  import ql_dsp_cfg_pkg::*;
#(
  parameter int MODE_W = QL_DSP_MODE_W,
  parameter logic [7:0] SYNC = QL_DSP_CFG_SYNC,
  parameter logic [0:MODE_W-1] MODE_RST = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cfg_valid_i,
  input  logic              cfg_data_i,
  output logic              cfg_ready_o,
  input  logic              abort_i,
  output logic [0:MODE_W-1] mode_o,
  output logic              done_o,
  output logic              err_o,
  output logic              busy_o,
  input  logic              rb_req_i,
  output logic              rb_valid_o,
  output logic              rb_data_o
);
  localparam logic [6:0] LAST_K = 7'(MODE_W - 1);
  cfg_state_e state_q, state_d;
  logic [7:0] sr_q, sr_d, rx_q, rx_d, sr_nxt, rx_nxt, crc;
  logic [6:0] cnt_q, cnt_d;
  logic [0:MODE_W-1] shadow_q, shadow_d, mode_q, mode_d;
  logic done_q, done_d, err_q, err_d;
  logic xfer, sync_hit, load_end, crc_end, rb_start, rb_end, match;
  assign xfer = cfg_valid_i & cfg_ready_o & ~abort_i;
  assign sr_nxt = {sr_q[6:0], cfg_data_i};
  assign rx_nxt = {rx_q[6:0], cfg_data_i};
  assign sync_hit = xfer && state_q == HUNT && sr_nxt == SYNC;
  assign load_end = xfer && state_q == LOAD && cnt_q == LAST_K;
  assign crc_end = xfer && state_q == CRC && cnt_q == 7'd7;
  assign match = rx_nxt == crc;
`ifdef QL_DSP_CFG_READBACK_EN
  assign rb_start = state_q == HUNT && !cfg_valid_i && rb_req_i;
  assign rb_end = state_q == RDBK && cnt_q == LAST_K;
`else
  logic unused_rb;
  assign unused_rb = rb_req_i;
  assign rb_start = 1'b0;
  assign rb_end = 1'b0;
`endif
  ql_dsp_cfg_crc8 u_crc (
    .clock (clock),
    .reset (reset),
    .clear (sync_hit | abort_i),
    .en    (xfer && state_q == LOAD),
    .bit_i (cfg_data_i),
    .crc_o (crc)
  );
  always_ff @(posedge clock or posedge reset)
    if (reset) state_q <= HUNT;
    else state_q <= state_d;
  always_comb
    state_d = abort_i ? HUNT : sync_hit ? LOAD : load_end ? CRC : crc_end ? COMMIT :
              rb_start ? RDBK : (state_q == COMMIT || rb_end) ? HUNT : state_q;
  always_comb begin
    sr_d = (abort_i || sync_hit) ? 8'h00 : (xfer && state_q == HUNT) ? sr_nxt : sr_q;
    rx_d = (xfer && state_q == CRC) ? rx_nxt : rx_q;
    cnt_d = (abort_i || sync_hit || load_end || crc_end || rb_start || rb_end) ? 7'd0 :
            ((xfer && state_q inside {LOAD, CRC}) || state_q == RDBK) ? cnt_q + 7'd1 : cnt_q;
    shadow_d = shadow_q;
    if (xfer && state_q == LOAD) shadow_d[cnt_q] = cfg_data_i;
    mode_d = (crc_end && match) ? shadow_q : mode_q;
    done_d = crc_end && match;
    err_d = crc_end && !match;
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      sr_q <= 8'h00;
      rx_q <= 8'h00;
      cnt_q <= 7'd0;
      shadow_q <= '0;
      mode_q <= MODE_RST;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      sr_q <= sr_d;
      rx_q <= rx_d;
      cnt_q <= cnt_d;
      shadow_q <= shadow_d;
      mode_q <= mode_d;
      done_q <= done_d;
      err_q <= err_d;
    end
  always_comb begin
    cfg_ready_o = state_q inside {HUNT, LOAD, CRC};
    busy_o = state_q != HUNT;
    mode_o = mode_q;
    done_o = done_q;
    err_o = err_q;
`ifdef QL_DSP_CFG_READBACK_EN
    rb_valid_o = state_q == RDBK;
    rb_data_o = state_q == RDBK && mode_q[cnt_q];
`else
    rb_valid_o = 1'b0;
    rb_data_o = 1'b0;
`endif
  end
endmodule

// File: tb/tb_ql_dsp_cfg_loader.sv
// tb_ql_dsp_cfg_loader: table-driven frames plus abort, reset and readback sequences.
module tb_ql_dsp_cfg_loader;
  localparam logic [7:0] SYNC_B = 8'hA5;
  logic clock = 1'b0, reset = 1'b1, cfg_valid_i = 1'b0, cfg_data_i = 1'b0, abort_i = 1'b0, rb_req_i = 1'b0;
  logic cfg_ready_o, done_o, err_o, busy_o, rb_valid_o, rb_data_o;
  logic [0:84] mode_o;
  int checks = 0, errors = 0, done_cnt = 0, err_cnt = 0, ready_bad = 0;

  ql_dsp_cfg_loader dut (
    .clock(clock), .reset(reset), .cfg_valid_i(cfg_valid_i), .cfg_data_i(cfg_data_i),
    .cfg_ready_o(cfg_ready_o), .abort_i(abort_i), .mode_o(mode_o), .done_o(done_o),
    .err_o(err_o), .busy_o(busy_o), .rb_req_i(rb_req_i), .rb_valid_o(rb_valid_o),
    .rb_data_o(rb_data_o)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (done_o) done_cnt++;
    if (err_o) err_cnt++;
    if (!reset && !cfg_ready_o && !done_o && !err_o && !rb_valid_o) ready_bad++;
  end

  typedef struct {
    logic [7:0] pre;
    bit use_pre;
    logic [0:84] payload;
    bit crc_auto;
    logic [7:0] crc;
    bit gaps;
    bit exp_done;
    logic [0:84] exp_mode;
  } vec_t;
  vec_t vecs[5];

  function automatic logic [7:0] crc_of(input logic [0:84] p);
    logic [7:0] c = 8'h00;
    logic fb;
    for (int k = 0; k < 85; k++) begin
      fb = c[7] ^ p[k];
      c = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    end
    return c;
  endfunction

  task automatic chk(input string name, input logic [84:0] act, input logic [84:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send_bit(input logic b, input bit gap);
    int w = 0;
    if (gap) repeat ($urandom_range(0, 2)) @(negedge clock);
    @(negedge clock);
    cfg_valid_i = 1'b1;
    cfg_data_i = b;
    while (!cfg_ready_o && w < 200) begin
      @(negedge clock);
      w++;
    end
    if (w >= 200) chk("ready_timeout", 85'(cfg_ready_o), 85'd1);
    @(posedge clock);
    #1 cfg_valid_i = 1'b0;
  endtask

  task automatic send_head(input logic [7:0] pre, input bit use_pre, input logic [0:84] p,
                           input int nbits, input bit gap);
    logic [7:0] s = SYNC_B;
    if (use_pre) for (int i = 7; i >= 0; i--) send_bit(pre[i], gap);
    for (int i = 7; i >= 0; i--) send_bit(s[i], gap);
    for (int k = 0; k < nbits; k++) send_bit(p[k], gap);
  endtask

  task automatic send_frame(input logic [7:0] pre, input bit use_pre, input logic [0:84] p,
                            input logic [7:0] c, input bit gap);
    send_head(pre, use_pre, p, 85, gap);
    for (int i = 7; i >= 0; i--) send_bit(c[i], gap);
    @(negedge clock);
  endtask

  task automatic check_commit(input string tag, input bit exp_done, input logic [0:84] exp_mode);
    chk({tag, "_done"}, 85'(done_o), 85'(exp_done));
    chk({tag, "_err"}, 85'(err_o), 85'(!exp_done));
    chk({tag, "_mode"}, mode_o, exp_mode);
    chk({tag, "_ready_commit"}, 85'(cfg_ready_o), 85'd0);
    chk({tag, "_busy_commit"}, 85'(busy_o), 85'd1);
    @(negedge clock);
    chk({tag, "_done_pulse"}, 85'(done_o | err_o), 85'd0);
    chk({tag, "_ready_after"}, 85'(cfg_ready_o), 85'd1);
    chk({tag, "_busy_after"}, 85'(busy_o), 85'd0);
  endtask

  initial begin
    logic [0:84] pat, p3, p5;
    logic [7:0] c;
    int d0;
    pat = 85'h1_5555_5555_5555_5555_5555;
    p3 = 85'h0_ABCD_1234_5678_9ABC_DEF0;
    p5 = 85'h0_0F0F_00FF_F0F0_3C3C_A5A5;
    vecs[0] = '{pre: 8'h00, use_pre: 0, payload: '0, crc_auto: 0, crc: 8'h00, gaps: 0, exp_done: 1, exp_mode: '0};
    vecs[1] = '{pre: 8'h00, use_pre: 0, payload: 85'h1, crc_auto: 1, crc: 8'h00, gaps: 0, exp_done: 1, exp_mode: 85'h1};
    vecs[2] = '{pre: 8'h00, use_pre: 0, payload: '0, crc_auto: 0, crc: 8'h01, gaps: 0, exp_done: 0, exp_mode: 85'h1};
    vecs[3] = '{pre: 8'h5A, use_pre: 1, payload: p3, crc_auto: 1, crc: 8'h00, gaps: 1, exp_done: 1, exp_mode: p3};
    vecs[4] = '{pre: 8'h00, use_pre: 0, payload: pat, crc_auto: 1, crc: 8'h00, gaps: 0, exp_done: 1, exp_mode: pat};

    repeat (2) @(negedge clock);
    chk("rst_mode", mode_o, 85'h0);
    chk("rst_ready", 85'(cfg_ready_o), 85'd1);
    reset = 1'b0;
    @(negedge clock);
    chk("rst_outs", {done_o, err_o, busy_o, rb_valid_o, rb_data_o}, 85'd0);

    for (int i = 0; i < 5; i++) begin
      c = vecs[i].crc_auto ? crc_of(vecs[i].payload) : vecs[i].crc;
      send_frame(vecs[i].pre, vecs[i].use_pre, vecs[i].payload, c, vecs[i].gaps);
      check_commit($sformatf("vec%0d", i), vecs[i].exp_done, vecs[i].exp_mode);
    end

    d0 = done_cnt;
    send_head(8'h00, 0, '1, 40, 0);
    @(negedge clock);
    abort_i = 1'b1;
    cfg_valid_i = 1'b1;
    cfg_data_i = 1'b1;
    @(posedge clock);
    #1 abort_i = 1'b0;
    cfg_valid_i = 1'b0;
    @(negedge clock);
    chk("abort_busy", 85'(busy_o), 85'd0);
    chk("abort_mode", mode_o, pat);
    send_frame(8'h00, 0, p5, crc_of(p5), 0);
    check_commit("after_abort", 1, p5);
    chk("abort_one_commit", 85'(done_cnt - d0), 85'd1);

    send_head(8'h00, 0, '1, 40, 0);
    #1 reset = 1'b1;
    @(negedge clock);
    chk("midreset_mode", mode_o, 85'h0);
    chk("midreset_busy", 85'(busy_o), 85'd0);
    reset = 1'b0;

    send_frame(8'h00, 0, pat, crc_of(pat), 0);
    check_commit("rb_frame", 1, pat);
    rb_req_i = 1'b1;
    @(posedge clock);
    #1 rb_req_i = 1'b0;
`ifdef QL_DSP_CFG_READBACK_EN
    for (int k = 0; k < 85; k++) begin
      @(negedge clock);
      chk($sformatf("rb_bit%0d", k), {rb_valid_o, rb_data_o, cfg_ready_o}, {pat[k] ? 3'b110 : 3'b100});
    end
    @(negedge clock);
    chk("rb_end", {rb_valid_o, cfg_ready_o}, 85'b01);
`else
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      chk($sformatf("norb_%0d", k), {rb_valid_o, rb_data_o, cfg_ready_o}, 85'b001);
    end
`endif
    chk("done_total", 85'(done_cnt), 85'd6);
    chk("err_total", 85'(err_cnt), 85'd1);
    chk("ready_only_commit", 85'(ready_bad), 85'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
